// File: rtl/fpu_issue_ctrl.sv
// Issue/capture controller for the single-precision FPU: holds one request on the FPU inputs
// for its op latency, then returns the captured result. Optional STICKY_FLAGS_EN adds sticky flags.
module fpu_issue_ctrl #(
    parameter int LAT_ADDSUB = 7,
    parameter int LAT_MUL    = 12,
    parameter int LAT_DIV    = 35,
    parameter int LAT_SQRT   = 35
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fpu_op,
    input  logic [1:0]  in_rmode,
    input  logic [31:0] in_opa,
    input  logic [31:0] in_opb,
    output logic [2:0]  fpu_op,
    output logic [1:0]  fpu_rmode,
    output logic [31:0] fpu_opa,
    output logic [31:0] fpu_opb,
    input  logic [31:0] fpu_out,
    input  logic [7:0]  fpu_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_out,
    output logic [7:0]  res_flags,
    output logic        busy,
    input  logic        sticky_clr,
    output logic [7:0]  sticky_flags
);

    localparam int LAT_M01 = (LAT_ADDSUB > LAT_MUL) ? LAT_ADDSUB : LAT_MUL;
    localparam int LAT_M23 = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT;
    localparam int LAT_MAX = (LAT_M01 > LAT_M23) ? LAT_M01 : LAT_M23;
    localparam int CW      = $clog2(LAT_MAX + 1);

    localparam logic [31:0] QNAN_OUT   = 32'h7FC0_0000;
    localparam logic [7:0]  QNAN_FLAGS = 8'h20;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ill_q, ill_d;
    logic [2:0]    op_q, op_d;
    logic [1:0]    rmode_q, rmode_d;
    logic [31:0]   opa_q, opa_d;
    logic [31:0]   opb_q, opb_d;
    logic          res_valid_q, res_valid_d;
    logic [31:0]   res_out_q, res_out_d;
    logic [7:0]    res_flags_q, res_flags_d;

    logic          capture;
    logic [31:0]   cap_out;
    logic [7:0]    cap_flags;

    function automatic logic [CW-1:0] lat_m1(input logic [2:0] op);
        case (op)
            3'b000, 3'b001: lat_m1 = CW'(LAT_ADDSUB - 1);
            3'b010:         lat_m1 = CW'(LAT_MUL - 1);
            3'b011:         lat_m1 = CW'(LAT_DIV - 1);
            default:        lat_m1 = CW'(LAT_SQRT - 1);
        endcase
    endfunction

    // Illegal ops bypass the FPU and report a canonical quiet NaN.
    assign cap_out   = ill_q ? QNAN_OUT : fpu_out;
    assign cap_flags = ill_q ? QNAN_FLAGS : fpu_flags;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ill_d       = ill_q;
        op_d        = op_q;
        rmode_d     = rmode_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_valid_d = res_valid_q;
        res_out_d   = res_out_q;
        res_flags_d = res_flags_q;
        capture     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = in_fpu_op;
                    rmode_d = in_rmode;
                    opa_d   = in_opa;
                    opb_d   = in_opb;
                    state_d = S_BUSY;
                    // Counter is always 0 in IDLE, so an illegal op captures on the next edge.
                    if (in_fpu_op <= 3'b100) begin
                        cnt_d = lat_m1(in_fpu_op);
                        ill_d = 1'b0;
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    capture     = 1'b1;
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    res_out_d   = cap_out;
                    res_flags_d = cap_flags;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ill_q       <= 1'b0;
            op_q        <= '0;
            rmode_q     <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_valid_q <= 1'b0;
            res_out_q   <= '0;
            res_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ill_q       <= ill_d;
            op_q        <= op_d;
            rmode_q     <= rmode_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            res_valid_q <= res_valid_d;
            res_out_q   <= res_out_d;
            res_flags_q <= res_flags_d;
        end
    end

`ifdef STICKY_FLAGS_EN
    logic [7:0] sticky_q, sticky_d;

    // A clear coinciding with a capture keeps only the freshly captured flags.
    always_comb begin
        sticky_d = sticky_clr ? 8'h00 : sticky_q;
        if (capture) begin
            sticky_d = sticky_d | cap_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_sticky;
    assign unused_sticky = sticky_clr ^ capture;
    assign sticky_flags  = 8'h00;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign fpu_op    = op_q;
    assign fpu_rmode = rmode_q;
    assign fpu_opa   = opa_q;
    assign fpu_opb   = opb_q;
    assign res_valid = res_valid_q;
    assign res_out   = res_out_q;
    assign res_flags = res_flags_q;

endmodule
